// File: rtl/libv_pkg.sv
// Shared definitions for the libv queue issue controller.
//   issue_state_e : controller FSM state encoding
//   REPLAY_CNT_W  : width of the saturating replay counter
package libv_pkg;

  localparam int REPLAY_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_ISSUE   = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_BACKOFF = 2'd2,
    ST_REPLAY  = 2'd3
  } issue_state_e;

endpackage

// File: rtl/libv_queue_issue_ctrl.sv
// Issue controller for a speculative-read queue. Entries are issued to a
// consumer with a valid/ready handshake and retired by in-order responses.
// An ok response commits the head; a nack stops issue, drains every still
// in-flight entry, waits BACKOFF cycles and rewinds the queue's speculative
// read pointer to the committed pointer (replay).
//
// Ports:
//   clk, rst            sole clock; synchronous active-high reset
//   flush               abandon all queue contents (forwarded as q_flush)
//   q_empty, q_pop_data queue status/head at the speculative read pointer
//   q_pop, q_commit,    queue control strobes
//   q_replay, q_flush
//   iss_vld/data/rdy    consumer issue handshake
//   rsp_vld, rsp_nack   in-order completion, nack=1 means failure
//   busy, replay_cnt    status; replay_cnt saturates at its maximum
module libv_queue_issue_ctrl
  import libv_pkg::*;
#(
  parameter int W       = 32,
  parameter int M       = 4,
  parameter int BACKOFF = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    q_empty,
  input  logic [W-1:0]            q_pop_data,
  output logic                    q_pop,
  output logic                    q_commit,
  output logic                    q_replay,
  output logic                    q_flush,
  output logic                    iss_vld,
  output logic [W-1:0]            iss_data,
  input  logic                    iss_rdy,
  input  logic                    rsp_vld,
  input  logic                    rsp_nack,
  output logic                    busy,
  output logic [REPLAY_CNT_W-1:0] replay_cnt
);

  localparam int IW = $clog2(M + 1);
  localparam int BW = (BACKOFF > 1) ? $clog2(BACKOFF) : 1;

  issue_state_e            state_reg,      state_next;
  logic [IW-1:0]           inflight_reg,   inflight_next;
  logic [BW-1:0]           bo_cnt_reg,     bo_cnt_next;
  logic [REPLAY_CNT_W-1:0] replay_cnt_reg, replay_cnt_next;

  // A response with nothing outstanding is a stray and is ignored.
  logic rsp_evt;
  assign rsp_evt = rsp_vld && (inflight_reg != '0);

  // Issue only from ISSUE with room for another outstanding entry; reset
  // holds the handshake quiet regardless of queue status.
  assign iss_vld  = !rst && (state_reg == ST_ISSUE) && !q_empty &&
                    (inflight_reg < IW'(M));
  assign iss_data = q_pop_data;
  assign q_pop    = iss_vld && iss_rdy;

  assign q_commit = !rst && !flush && (state_reg == ST_ISSUE) &&
                    rsp_evt && !rsp_nack;
  assign q_replay = !rst && !flush && (state_reg == ST_REPLAY);
  assign q_flush  = !rst && flush;

  assign busy       = (state_reg != ST_ISSUE) || (inflight_reg != '0);
  assign replay_cnt = replay_cnt_reg;

  always_comb begin
    state_next      = state_reg;
    bo_cnt_next     = bo_cnt_reg;
    replay_cnt_next = replay_cnt_reg;
    // Transfer and response in the same cycle cancel out.
    inflight_next   = inflight_reg + IW'(q_pop) - IW'(rsp_evt);

    case (state_reg)
      ST_ISSUE: begin
        if (rsp_evt && rsp_nack) begin
          if (inflight_next == '0) begin
            state_next  = ST_BACKOFF;
            bo_cnt_next = BW'(BACKOFF - 1);
          end else begin
            state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Every response here belongs to an entry that will be replayed,
        // so nothing is committed.
        if (rsp_evt && (inflight_next == '0)) begin
          state_next  = ST_BACKOFF;
          bo_cnt_next = BW'(BACKOFF - 1);
        end
      end
      ST_BACKOFF: begin
        if (bo_cnt_reg == '0) begin
          state_next = ST_REPLAY;
        end else begin
          bo_cnt_next = bo_cnt_reg - 1'b1;
        end
      end
      ST_REPLAY: begin
        state_next = ST_ISSUE;
        if (replay_cnt_reg != '1) begin
          replay_cnt_next = replay_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = ST_ISSUE;
      end
    endcase

    // Flush wins over every other event but keeps the replay statistic.
    if (flush) begin
      state_next      = ST_ISSUE;
      inflight_next   = '0;
      bo_cnt_next     = '0;
      replay_cnt_next = replay_cnt_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_ISSUE;
      inflight_reg   <= '0;
      bo_cnt_reg     <= '0;
      replay_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      inflight_reg   <= inflight_next;
      bo_cnt_reg     <= bo_cnt_next;
      replay_cnt_reg <= replay_cnt_next;
    end
  end

endmodule

// File: tb/tb_libv_queue_issue_ctrl.sv
// Directed bench for libv_queue_issue_ctrl with a small behavioural
// speculative queue (write, speculative read and commit pointers).
module tb_libv_queue_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst, flush, iss_rdy, rsp_vld, rsp_nack;
  logic        q_empty, q_pop, q_commit, q_replay, q_flush;
  logic        iss_vld, busy;
  logic [31:0] q_pop_data, iss_data;
  logic [7:0]  replay_cnt;

  logic        push_en;
  logic [31:0] push_data;
  logic [31:0] mem [16];
  logic [3:0]  wr_ptr = '0, rd_ptr = '0, cm_ptr = '0;

  int n_cmp  = 0;
  int n_fail = 0;
  int cnt;

  always #5 clk = ~clk;

  libv_queue_issue_ctrl #(.W(32), .M(4), .BACKOFF(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .q_empty(q_empty), .q_pop_data(q_pop_data),
    .q_pop(q_pop), .q_commit(q_commit), .q_replay(q_replay), .q_flush(q_flush),
    .iss_vld(iss_vld), .iss_data(iss_data), .iss_rdy(iss_rdy),
    .rsp_vld(rsp_vld), .rsp_nack(rsp_nack),
    .busy(busy), .replay_cnt(replay_cnt)
  );

  assign q_empty    = (rd_ptr == wr_ptr);
  assign q_pop_data = mem[rd_ptr];

  always @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr] <= push_data;
      wr_ptr      <= wr_ptr + 4'd1;
    end
    if (q_flush) begin
      rd_ptr <= wr_ptr;
      cm_ptr <= wr_ptr;
    end else begin
      if (q_replay)     rd_ptr <= cm_ptr;
      else if (q_pop)   rd_ptr <= rd_ptr + 4'd1;
      if (q_commit)     cm_ptr <= cm_ptr + 4'd1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push(input logic [31:0] d);
    push_en   = 1'b1;
    push_data = d;
    tick();
    push_en   = 1'b0;
  endtask

  // Counts cycles without q_replay (bounded), leaving time at the replay cycle.
  task automatic wait_replay(output int n);
    n = 0;
    settle();
    while (!q_replay && n < 20) begin
      n++;
      tick();
      settle();
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; iss_rdy = 1'b0; rsp_vld = 1'b0; rsp_nack = 1'b0;
    push_en = 1'b0; push_data = '0;
    tick(); tick();
    settle();
    check("rst_busy",       busy,       0);
    check("rst_replay_cnt", replay_cnt, 0);
    check("rst_iss_vld",    iss_vld,    0);
    rst = 1'b0;
    tick();

    // Three entries, three ok responses.
    push(32'h10); push(32'h11); push(32'h12);
    settle();
    check("t1_head_vld",  iss_vld,  1);
    check("t1_head_data", iss_data, 32'h10);
    iss_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("t1_pop",      q_pop,    1);
      check("t1_pop_data", iss_data, 32'h10 + i);
      tick();
    end
    settle();
    check("t1_vld_empty", iss_vld, 0);
    check("t1_busy_infl", busy,    1);
    rsp_vld = 1'b1; rsp_nack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("t1_commit", q_commit, 1);
      check("t1_busy",   busy,     1);
      tick();
    end
    rsp_vld = 1'b0;
    settle();
    check("t1_busy_done", busy, 0);

    // In-flight limit of 4 with six entries queued.
    iss_rdy = 1'b0;
    for (int i = 0; i < 6; i++) push(32'h20 + i);
    iss_rdy = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      settle();
      if (q_pop) cnt++;
      tick();
    end
    check("t2_pop_count", cnt, 4);
    settle();
    check("t2_vld_full", iss_vld, 0);
    rsp_vld = 1'b1;
    settle();
    check("t2_vld_rsp_cycle", iss_vld,  0);
    check("t2_commit",        q_commit, 1);
    tick();
    rsp_vld = 1'b0; iss_rdy = 1'b0;
    settle();
    check("t2_vld_after_rsp", iss_vld,  1);
    check("t2_data_after",    iss_data, 32'h24);
    flush = 1'b1; rsp_vld = 1'b1;
    settle();
    check("t2_q_flush",        q_flush,  1);
    check("t2_flush_nocommit", q_commit, 0);
    tick();
    flush = 1'b0; rsp_vld = 1'b0;
    settle();
    check("t2_busy_flushed", busy,    0);
    check("t2_vld_flushed",  iss_vld, 0);

    // Nack on A with B, C outstanding; D stays queued.
    push(32'h30); push(32'h31); push(32'h32); push(32'h33);
    iss_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("t3_pop", q_pop, 1);
      tick();
    end
    iss_rdy = 1'b0;
    rsp_vld = 1'b1; rsp_nack = 1'b1;
    settle();
    check("t3_nack_nocommit", q_commit, 0);
    tick();
    rsp_nack = 1'b0; iss_rdy = 1'b1;
    settle();
    check("t3_drain_busy",  busy,     1);
    check("t3_drain_vld",   iss_vld,  0);
    check("t3_drain_pop",   q_pop,    0);
    check("t3_drain_b_nc",  q_commit, 0);
    tick();
    settle();
    check("t3_drain_c_nc",  q_commit, 0);
    tick();
    rsp_vld = 1'b0; iss_rdy = 1'b0;
    wait_replay(cnt);
    check("t3_backoff_cycles", cnt,      8);
    check("t3_replay",         q_replay, 1);
    tick();
    settle();
    check("t3_replay_cnt", replay_cnt, 1);
    check("t3_no_replay2", q_replay,   0);
    check("t3_reissue_a",  iss_data,   32'h30);
    check("t3_reissue_v",  iss_vld,    1);
    do_flush();

    // Nack with one in flight: straight to BACKOFF.
    push(32'h40);
    iss_rdy = 1'b1;
    settle();
    check("t4_pop", q_pop, 1);
    tick();
    iss_rdy = 1'b0;
    rsp_vld = 1'b1; rsp_nack = 1'b1;
    settle();
    check("t4_nack_nocommit", q_commit, 0);
    tick();
    rsp_vld = 1'b0; rsp_nack = 1'b0;
    settle();
    check("t4_busy", busy, 1);
    wait_replay(cnt);
    check("t4_backoff_cycles", cnt,      8);
    check("t4_replay",         q_replay, 1);
    tick();
    settle();
    check("t4_replay_cnt", replay_cnt, 2);
    check("t4_reissue",    iss_data,   32'h40);
    do_flush();

    // Flush in the middle of BACKOFF.
    push(32'h50);
    iss_rdy = 1'b1;
    tick();
    iss_rdy = 1'b0;
    rsp_vld = 1'b1; rsp_nack = 1'b1;
    tick();
    rsp_vld = 1'b0; rsp_nack = 1'b0;
    tick(); tick(); tick();
    flush = 1'b1;
    settle();
    check("t5_q_flush",   q_flush,  1);
    check("t5_no_replay", q_replay, 0);
    tick();
    flush = 1'b0;
    settle();
    check("t5_busy_issue", busy, 0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      settle();
      if (q_replay) cnt++;
      tick();
    end
    check("t5_replays_after", cnt,        0);
    check("t5_replay_cnt",    replay_cnt, 2);

    // Reset in DRAIN with two in flight.
    push(32'h60); push(32'h61); push(32'h62); push(32'h63);
    iss_rdy = 1'b1;
    tick(); tick(); tick();
    iss_rdy = 1'b0;
    rsp_vld = 1'b1; rsp_nack = 1'b1;
    tick();
    rsp_nack = 1'b0;
    settle();
    check("t6_drain_busy", busy, 1);
    rst = 1'b1; flush = 1'b1; iss_rdy = 1'b1;
    settle();
    check("t6_rst_commit", q_commit, 0);
    check("t6_rst_flush",  q_flush,  0);
    check("t6_rst_vld",    iss_vld,  0);
    tick();
    flush = 1'b0; rsp_vld = 1'b0;
    settle();
    check("t6_rst_vld_nonempty", iss_vld, 0);
    check("t6_rst_pop",          q_pop,   0);
    tick();
    rst = 1'b0; iss_rdy = 1'b0;
    settle();
    check("t6_busy",       busy,       0);
    check("t6_replay_cnt", replay_cnt, 0);
    check("t6_head_vld",   iss_vld,    1);
    check("t6_head_data",  iss_data,   32'h63);
    rsp_vld = 1'b1; rsp_nack = 1'b1;
    settle();
    check("t6_stray_commit", q_commit, 0);
    tick();
    rsp_vld = 1'b0; rsp_nack = 1'b0;
    settle();
    check("t6_stray_busy", busy, 0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      settle();
      if (q_replay) cnt++;
      tick();
    end
    check("t6_no_replay", cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
